// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between two requesters.
// Ports: clk/rst(async low), req side addrN/dinN/reN/weN -> doutN/readyN, mem side maddr/mout/mre/mwe <- min/mready.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int WORD_WIDTH = 64,
  parameter int OFFSET     = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [WORD_WIDTH-1:0] din0,
  output logic [WORD_WIDTH-1:0] dout0,
  input  logic                  re0,
  input  logic                  we0,
  output logic                  ready0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [WORD_WIDTH-1:0] din1,
  output logic [WORD_WIDTH-1:0] dout1,
  input  logic                  re1,
  input  logic                  we1,
  output logic                  ready1,
  output logic [ADDR_WIDTH-1:0] maddr,
  output logic [WORD_WIDTH-1:0] mout,
  input  logic [WORD_WIDTH-1:0] min,
  output logic                  mre,
  output logic                  mwe,
  input  logic                  mready
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RESPOND = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LP_OFF = ADDR_WIDTH'(OFFSET);

  state_t                r_state;
  logic                  r_gnt;
  logic                  r_last;
  logic [ADDR_WIDTH-1:0] r_maddr;
  logic [WORD_WIDTH-1:0] r_mout;
  logic                  r_mre;
  logic                  r_mwe;
  logic [WORD_WIDTH-1:0] r_dout0;
  logic [WORD_WIDTH-1:0] r_dout1;
  logic                  r_ready0;
  logic                  r_ready1;

  logic                  w_req0;
  logic                  w_req1;
  logic                  w_pick1;
  logic [ADDR_WIDTH-1:0] w_addr1;

  assign w_req0  = re0 | we0;
  assign w_req1  = re1 | we1;
  // On a tie the port that was not served last wins.
  assign w_pick1 = w_req1 & (~w_req0 | ~r_last);
  // Port 1 lives in the upper part of the backing memory.
  assign w_addr1 = addr1 + LP_OFF;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_gnt    <= 1'b0;
      r_last   <= 1'b1;
      r_maddr  <= '0;
      r_mout   <= '0;
      r_mre    <= 1'b0;
      r_mwe    <= 1'b0;
      r_dout0  <= '0;
      r_dout1  <= '0;
      r_ready0 <= 1'b0;
      r_ready1 <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_req0 | w_req1) begin
            r_gnt   <= w_pick1;
            r_last  <= w_pick1;
            r_state <= S_ACCESS;
            if (w_pick1) begin
              r_maddr <= w_addr1;
              r_mout  <= din1;
              r_mwe   <= we1;
              r_mre   <= re1 & ~we1;
            end else begin
              r_maddr <= addr0;
              r_mout  <= din0;
              r_mwe   <= we0;
              r_mre   <= re0 & ~we0;
            end
          end
        end
        S_ACCESS: begin
          if (mready) begin
            r_mre   <= 1'b0;
            r_mwe   <= 1'b0;
            r_state <= S_RESPOND;
            if (r_gnt) begin
              r_ready1 <= 1'b1;
              if (r_mre) r_dout1 <= min;
            end else begin
              r_ready0 <= 1'b1;
              if (r_mre) r_dout0 <= min;
            end
          end
        end
        S_RESPOND: begin
          r_ready0 <= 1'b0;
          r_ready1 <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign maddr  = r_maddr;
  assign mout   = r_mout;
  assign mre    = r_mre;
  assign mwe    = r_mwe;
  assign dout0  = r_dout0;
  assign dout1  = r_dout1;
  assign ready0 = r_ready0;
  assign ready1 = r_ready1;

endmodule
